// File: rtl/alu_dispatch_pkg.sv
// Shared constants and types for the ALU opcode dispatch stage.
// Opcode encodings, default widths and the handshake FSM state type.
package alu_dispatch_pkg;

   localparam int unsigned OPCODE_W_DEF  = 5;
   localparam int unsigned NUM_OPS_DEF   = 8;
   localparam int unsigned MC_FIRST_DEF  = 6;
   localparam int unsigned MC_CYCLES_DEF = 32;

   localparam logic [OPCODE_W_DEF-1:0] OP_ADD = 5'd0;
   localparam logic [OPCODE_W_DEF-1:0] OP_SUB = 5'd1;
   localparam logic [OPCODE_W_DEF-1:0] OP_AND = 5'd2;
   localparam logic [OPCODE_W_DEF-1:0] OP_OR  = 5'd3;
   localparam logic [OPCODE_W_DEF-1:0] OP_SLL = 5'd4;
   localparam logic [OPCODE_W_DEF-1:0] OP_SRA = 5'd5;
   localparam logic [OPCODE_W_DEF-1:0] OP_MUL = 5'd6;
   localparam logic [OPCODE_W_DEF-1:0] OP_DIV = 5'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VALID,
      S_BUSY
   } state_e;

endpackage

// File: rtl/alu_op_onehot.sv
// Combinational opcode decoder: one-hot control lines plus illegal and
// multi-cycle classification.
module alu_op_onehot
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned OPCODE_W = OPCODE_W_DEF,
   parameter int unsigned NUM_OPS  = NUM_OPS_DEF,
   parameter int unsigned MC_FIRST = MC_FIRST_DEF
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [NUM_OPS-1:0]  onehot,
   output logic                illegal,
   output logic                multicycle
);

   // One extra bit so NUM_OPS == 2**OPCODE_W is still representable.
   localparam int unsigned     CMP_W      = OPCODE_W + 1;
   localparam logic [CMP_W-1:0] NUM_OPS_C  = CMP_W'(NUM_OPS);
   localparam logic [CMP_W-1:0] MC_FIRST_C = CMP_W'(MC_FIRST);

   logic [CMP_W-1:0] op_ext;

   assign op_ext = {1'b0, opcode};

   always_comb begin
      illegal    = (op_ext >= NUM_OPS_C);
      multicycle = ~illegal & (op_ext >= MC_FIRST_C);
      onehot     = '0;
      for (int k = 0; k < int'(NUM_OPS); k++) begin
         onehot[k] = (op_ext == CMP_W'(k));
      end
   end

endmodule

// File: rtl/alu_op_dispatch.sv
// Registered opcode dispatch with valid/ready handshake and multi-cycle stall.
// Define ALU_OP_DISPATCH_STATS_EN to build the saturating illegal-opcode counter.
module alu_op_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned OPCODE_W  = OPCODE_W_DEF,
   parameter int unsigned NUM_OPS   = NUM_OPS_DEF,
   parameter int unsigned MC_FIRST  = MC_FIRST_DEF,
   parameter int unsigned MC_CYCLES = MC_CYCLES_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] in_opcode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_OPS-1:0]  out_onehot,
   output logic                out_illegal,
   output logic                out_multicycle,
   output logic                busy,
   output logic [15:0]         illegal_count
);

   localparam int unsigned      CNT_W    = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_OPS-1:0] onehot_q, dec_onehot;
   logic               illegal_q, dec_illegal;
   logic               mc_q, dec_mc;
   logic               accept;

   alu_op_onehot #(
      .OPCODE_W (OPCODE_W),
      .NUM_OPS  (NUM_OPS),
      .MC_FIRST (MC_FIRST)
   ) u_decode (
      .opcode     (in_opcode),
      .onehot     (dec_onehot),
      .illegal    (dec_illegal),
      .multicycle (dec_mc)
   );

   // A held multi-cycle vector must drain into BUSY before anything new issues.
   assign in_ready = (state_q == S_IDLE) | ((state_q == S_VALID) & out_ready & ~mc_q);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (out_ready) begin
               if (mc_q) begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_LOAD;
               end else if (accept) begin
                  state_d = S_VALID;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Vector content is held outside VALID so downstream never sees X.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         onehot_q  <= '0;
         illegal_q <= 1'b0;
         mc_q      <= 1'b0;
      end else if (accept) begin
         onehot_q  <= dec_onehot;
         illegal_q <= dec_illegal;
         mc_q      <= dec_mc;
      end
   end

   assign out_valid      = (state_q == S_VALID);
   assign busy           = (state_q == S_BUSY);
   assign out_onehot     = onehot_q;
   assign out_illegal    = illegal_q;
   assign out_multicycle = mc_q;

`ifdef ALU_OP_DISPATCH_STATS_EN
   logic [15:0] illegal_cnt_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         illegal_cnt_q <= '0;
      end else if (accept & dec_illegal & (illegal_cnt_q != 16'hFFFF)) begin
         illegal_cnt_q <= illegal_cnt_q + 16'd1;
      end
   end

   assign illegal_count = illegal_cnt_q;
`else
   assign illegal_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Self-checking bench for alu_op_dispatch: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_alu_op_dispatch;

   localparam int MC_CYCLES = 32;
`ifdef ALU_OP_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clock     = 1'b0;
   logic       reset_n   = 1'b0;
   logic       in_valid  = 1'b0;
   logic [4:0] in_opcode = 5'd0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_onehot;
   logic       out_illegal;
   logic       out_multicycle;
   logic       busy;
   logic [15:0] illegal_count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   alu_op_dispatch #(
      .OPCODE_W  (5),
      .NUM_OPS   (8),
      .MC_FIRST  (6),
      .MC_CYCLES (MC_CYCLES)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_opcode      (in_opcode),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_onehot     (out_onehot),
      .out_illegal    (out_illegal),
      .out_multicycle (out_multicycle),
      .busy           (busy),
      .illegal_count  (illegal_count)
   );

   // Drive one cycle of inputs; rdy is in_ready just before the edge, and
   // registered outputs are settled on return.
   task automatic cyc(input logic v, input logic [4:0] op, input logic r, output logic rdy);
      @(negedge clock);
      in_valid  = v;
      in_opcode = op;
      out_ready = r;
      #1 rdy = in_ready;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL reset_onehot: got %h want 00", out_onehot); end
      total++; if (out_illegal !== 1'b0 || out_multicycle !== 1'b0) begin bad++; $display("FAIL reset_flags: got ill=%b mc=%b want 0 0", out_illegal, out_multicycle); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (illegal_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", illegal_count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      release_reset();
   endtask

   task automatic test_single();
      logic rdy;
      cyc(1'b1, 5'd1, 1'b1, rdy);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", rdy); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
      total++; if (out_onehot !== 8'b0000_0010) begin bad++; $display("FAIL single_onehot: got %b want 00000010", out_onehot); end
      total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL single_illegal: got %b want 0", out_illegal); end
      cyc(1'b0, 5'd0, 1'b1, rdy);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      logic rdy;
      int ops[5] = '{0, 2, 3, 4, 5};
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 5'(ops[i]), 1'b1, rdy);
         total++; if (rdy !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, rdy); end
         total++; if (out_valid !== 1'b1 || out_onehot !== 8'(1 << ops[i])) begin
            bad++; $display("FAIL stream_vec[%0d]: got v=%b oh=%h want v=1 oh=%h", i, out_valid, out_onehot, 8'(1 << ops[i]));
         end
      end
      cyc(1'b0, 5'd0, 1'b1, rdy);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_multicycle();
      logic rdy;
      int   n;
      cyc(1'b1, 5'd6, 1'b1, rdy);
      total++; if (out_valid !== 1'b1 || out_multicycle !== 1'b1 || out_onehot !== 8'h40) begin
         bad++; $display("FAIL mc_vec: got v=%b mc=%b oh=%h want 1 1 40", out_valid, out_multicycle, out_onehot);
      end
      // Dispatch edge with OP_ADD already queued.
      cyc(1'b1, 5'd0, 1'b1, rdy);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL mc_dispatch_ready: got %b want 0", rdy); end
      total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mc_dispatch: got busy=%b v=%b want 1 0", busy, out_valid); end
      n = 1;
      for (int i = 0; i < 40 && busy === 1'b1; i++) begin
         cyc(1'b1, 5'd0, 1'b1, rdy);
         total++; if (rdy !== 1'b0) begin bad++; $display("FAIL mc_stall_ready[%0d]: got %b want 0", i, rdy); end
         if (busy === 1'b1) n++;
      end
      total++; if (n != MC_CYCLES) begin bad++; $display("FAIL mc_busy_len: got %0d want %0d", n, MC_CYCLES); end
      cyc(1'b1, 5'd0, 1'b1, rdy);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL mc_after_ready: got %b want 1", rdy); end
      total++; if (out_valid !== 1'b1 || out_onehot !== 8'h01) begin bad++; $display("FAIL mc_after_add: got v=%b oh=%h want 1 01", out_valid, out_onehot); end
      cyc(1'b0, 5'd0, 1'b1, rdy);
   endtask

   task automatic test_backpressure();
      logic rdy;
      cyc(1'b1, 5'd0, 1'b0, rdy);
      total++; if (rdy !== 1'b1 || out_valid !== 1'b1 || out_onehot !== 8'h01) begin
         bad++; $display("FAIL bp_accept: got rdy=%b v=%b oh=%h want 1 1 01", rdy, out_valid, out_onehot);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 5'd3, 1'b0, rdy);
         total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, rdy); end
         total++; if (out_valid !== 1'b1 || out_onehot !== 8'h01) begin
            bad++; $display("FAIL bp_hold[%0d]: got v=%b oh=%h want 1 01", i, out_valid, out_onehot);
         end
      end
      cyc(1'b0, 5'd0, 1'b1, rdy);
      total++; if (rdy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got rdy=%b v=%b want 1 0", rdy, out_valid); end
   endtask

   task automatic test_illegal();
      logic rdy;
      logic [4:0] ops[2] = '{5'd20, 5'd31};
      do_reset();
      release_reset();
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, ops[i], 1'b1, rdy);
         total++; if (out_valid !== 1'b1 || out_onehot !== 8'h00 || out_illegal !== 1'b1 || out_multicycle !== 1'b0) begin
            bad++; $display("FAIL illegal_vec[%0d]: got v=%b oh=%h ill=%b mc=%b want 1 00 1 0", i, out_valid, out_onehot, out_illegal, out_multicycle);
         end
      end
      cyc(1'b0, 5'd0, 1'b1, rdy);
      total++; if (illegal_count !== (STATS ? 16'd2 : 16'd0)) begin
         bad++; $display("FAIL illegal_count: got %0d want %0d", illegal_count, STATS ? 2 : 0);
      end
   endtask

   task automatic test_reset_mid_busy();
      logic rdy;
      cyc(1'b1, 5'd7, 1'b1, rdy);
      cyc(1'b0, 5'd0, 1'b1, rdy);
      for (int i = 0; i < 9; i++) cyc(1'b0, 5'd0, 1'b1, rdy);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmb_pre_busy: got %b want 1", busy); end
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rmb_state: got busy=%b v=%b want 0 0", busy, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmb_ready: got %b want 1", in_ready); end
      total++; if (illegal_count !== 16'd0) begin bad++; $display("FAIL rmb_count: got %0d want 0", illegal_count); end
      release_reset();
   endtask

   task automatic test_random();
      logic       rdy, v, r, exp_rdy, acc, held_mc;
      logic [4:0] op;
      bit   m_hold;
      int   m_op, m_stall, m_ill;
      do_reset();
      release_reset();
      m_hold = 0; m_op = 0; m_stall = 0; m_ill = 0;
      for (int i = 0; i < 600; i++) begin
         v  = ($urandom_range(0, 9) < 7);
         r  = ($urandom_range(0, 9) < 6);
         op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         held_mc = m_hold && (m_op >= 6) && (m_op < 8);
         exp_rdy = (m_stall == 0) && (!m_hold || (r && !held_mc));
         cyc(v, op, r, rdy);
         total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, rdy, exp_rdy); end
         acc = v && exp_rdy;
         if (m_stall > 0) begin
            m_stall--;
         end else if (held_mc && r) begin
            m_hold  = 0;
            m_stall = MC_CYCLES;
         end else begin
            if (m_hold && r) m_hold = 0;
            if (acc) begin
               m_hold = 1;
               m_op   = int'(op);
               if (m_op >= 8 && m_ill < 65535) m_ill++;
            end
         end
         total++; if (out_valid !== m_hold || busy !== (m_stall > 0)) begin
            bad++; $display("FAIL rand_state[%0d]: got v=%b busy=%b want %b %b", i, out_valid, busy, m_hold, m_stall > 0);
         end
         if (m_hold) begin
            total++;
            if (out_onehot !== ((m_op < 8) ? 8'(1 << m_op) : 8'h00) || out_illegal !== (m_op >= 8) ||
                out_multicycle !== (m_op >= 6 && m_op < 8)) begin
               bad++; $display("FAIL rand_vec[%0d]: op=%0d got oh=%h ill=%b mc=%b", i, m_op, out_onehot, out_illegal, out_multicycle);
            end
         end
         total++; if (illegal_count !== (STATS ? 16'(m_ill) : 16'd0)) begin
            bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, illegal_count, STATS ? m_ill : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_multicycle();
      test_backpressure();
      test_illegal();
      test_reset_mid_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_dispatch.md
Name: alu_op_dispatch

Overview:
- Registered, parametrised successor to the ALU opcode decoder. Accepts an opcode over a valid/ready handshake and presents a registered one-hot ALU control vector downstream.
- Flags illegal opcodes.
- Stalls issue while a multi-cycle operation (MUL/DIV class) occupies the ALU.
- Sits between the instruction-decode stage and the ALU datapath.

Parameters:
- OPCODE_W, 5, opcode width in bits.
- NUM_OPS, 8, number of one-hot lines; legal opcodes are 0..NUM_OPS-1 (NUM_OPS <= 2**OPCODE_W).
- MC_FIRST, 6, lowest opcode that is multi-cycle; opcodes MC_FIRST..NUM_OPS-1 are multi-cycle.
- MC_CYCLES, 32, number of stall cycles after a multi-cycle op is dispatched (>= 2).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clock.
- in_valid  in  1  upstream opcode valid.
- in_ready  out  1  block can accept an opcode this cycle.
- in_opcode  in  OPCODE_W  opcode.
- out_valid  out  1  one-hot vector valid.
- out_ready  in  1  ALU accepts vector.
- out_onehot  out  NUM_OPS  bit k set iff registered opcode == k.
- out_illegal  out  1  registered opcode >= NUM_OPS.
- out_multicycle  out  1  registered opcode in MC_FIRST..NUM_OPS-1.
- busy  out  1  multi-cycle stall in progress.
- illegal_count  out  16  illegal opcodes accepted (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a clock edge, in any state, including mid-BUSY):
  - state->IDLE, stall counter=0.
  - out_valid, out_onehot, out_illegal, out_multicycle, busy, illegal_count all 0.
- States:
  - IDLE: no vector held.
  - VALID: vector held, out_valid=1.
  - BUSY: multi-cycle stall.
- in_ready = (state==IDLE) | (state==VALID & out_ready & !out_multicycle). Combinational. in_ready never depends on in_valid.
- Accept = in_valid & in_ready. On accept, at the next edge:
  - Register the decoded opcode.
  - Go to VALID.
  - Latency from accept to out_valid is 1 cycle.
- IDLE:
  - accept -> VALID.
  - otherwise stay in IDLE.
- VALID: outputs are stable while out_ready=0.
  - out_ready=1 & !out_multicycle & accept -> stay VALID with the new vector (back-to-back, 1 op/cycle).
  - out_ready=1 & !out_multicycle & !accept -> IDLE, out_valid=0.
  - out_ready=1 & out_multicycle -> BUSY. Load counter with MC_CYCLES-1. out_valid=0. No accept is possible in this cycle.
- BUSY:
  - busy=1, in_ready=0.
  - Counter decrements each cycle. When counter==0, go to IDLE at the next edge.
  - busy is high for exactly MC_CYCLES cycles after the dispatch edge.
- Illegal opcode:
  - out_onehot=0, out_illegal=1, out_multicycle=0.
  - Otherwise handled like a single-cycle op: it must still be handshaken.
- Legal opcode:
  - Exactly one out_onehot bit set, out_illegal=0.
- in_opcode is ignored when in_valid=0. out_* content is don't-care when out_valid=0, but is held at its last value (no X).

Optional Feature:
- Macro: ALU_OP_DISPATCH_STATS_EN.
- Defined:
  - illegal_count increments by 1 on every accept of an illegal opcode.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined:
  - illegal_count is tied to 0.
  - No counter flops are synthesised.
  - The port remains, so the bench is unchanged.

Decomposition:
- Package alu_dispatch_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRA=5, OP_MUL=6, OP_DIV=7.
  - State enum {S_IDLE, S_VALID, S_BUSY}.
  - Default widths.
- Sub-module alu_op_onehot, purely combinational, parametrised by OPCODE_W/NUM_OPS/MC_FIRST:
  - Inputs: opcode.
  - Outputs: one-hot, illegal, multicycle.
- The top level holds the handshake FSM, output register, stall counter and stats counter.

Test Plan:
- Reset, then present OP_SUB (1) with in_valid=1 and out_ready=1 -> out_valid=1 one cycle later, out_onehot=8'b0000_0010, out_illegal=0.
- Stream opcodes 0,2,3,4,5 on consecutive cycles with out_ready=1 -> in_ready stays 1, five consecutive out_valid cycles, one-hots 01,04,08,10,20.
- Present OP_MUL (6) with MC_CYCLES=32; hold out_ready=1 and in_valid=1 with OP_ADD queued ->
  - busy=1 and in_ready=0 for exactly 32 cycles after the dispatch edge.
  - OP_ADD is accepted on the first cycle after busy falls.
- Present OP_ADD with out_ready=0 for 5 cycles, then 1 -> out_valid and out_onehot=01 stable for all 6 cycles, in_ready=0 during the stall.
- Present opcode 5'd20, then 5'd31 -> out_onehot=0 and out_illegal=1 for both; illegal_count=2 with ALU_OP_DISPATCH_STATS_EN, 0 without.
- Assert reset_n=0 for 1 cycle at stall cycle 10 of OP_DIV -> next cycle busy=0, out_valid=0, in_ready=1, illegal_count=0.
